matrix3x3_calculator: RTL and testbench
=======================================

Name: matrix3x3_calculator

Overview:
- Sequential 3x3 unsigned integer matrix multiplier: Result = A x B.
- Operands and result are flat packed buses of nine 16-bit elements each.
- Computes one result element per clock through a single 3-term dot-product unit, then commits the full matrix.
- Sits as a compute slave behind a simple start/done handshake.

Parameters:
- DATA_W, 16, element width in bits; operands, products and results are truncated to this width.
- N, 3, matrix dimension. Only N=3 is required to be supported.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only while idle.
- A  in  144  left matrix, row-major packed.
- B  in  144  right matrix, row-major packed.
- busy  out  1  high while a multiplication is in progress.
- done  out  1  one-cycle pulse when Result is updated.
- Result  out  144  product matrix, row-major packed, held between operations.

Behaviour:
- Packing: element k = 3*row + col occupies bits [143-16k : 128-16k]. Element (0,0) is at the MSBs [143:128]; element (2,2) is at [15:0]. The same layout applies to A, B and Result.
- Arithmetic:
  - C[i][j] = sum over m of A[i][m]*B[m][j], all operands unsigned.
  - Full-precision 32-bit products and 34-bit sum, then truncated to the low 16 bits (modulo 2^16).
  - No saturation; no overflow flag.
- Reset (rst=1 at a rising edge): Result=0, busy=0, done=0, internal index=0, state=IDLE. Reset has priority over everything and aborts any in-flight operation.
- States:
  - IDLE: busy=0. On start=1, latch A and B into internal operand registers, set index=0, go to RUN, and assert busy from the next cycle.
  - RUN: busy=1. Each cycle, compute element[index] from the latched operands, write it into a shadow result register, and increment the index.
  - When index 8 is written, copy the shadow register to Result in the same edge, pulse done=1 for one cycle, set busy=0, and return to IDLE.
- Latency: start captured at edge E0; elements computed at edges E1..E9; Result and done change at edge E9. done is high for exactly the cycle following E9.
- Result changes only at commit. The previous Result stays stable throughout RUN.
- A and B may change freely after the capture edge without affecting the operation in progress.
- start while busy=1 is ignored; no queuing.
- start in the cycle done is high is accepted, since the block is already IDLE. This gives back-to-back operations every 10 cycles.
- No combinational path from any input to any output.

Decomposition:
- Shared package matrix_calc_pkg:
  - DATA_W and N constants.
  - Derived bus width N*N*DATA_W.
  - Element slice helper function (row, col) -> bit offset.
  - State enum {IDLE, RUN}.
- One sub-module: matrix_dot_product. It is purely combinational: three 16-bit pairs in, 16-bit truncated sum out.
- The top level contains the FSM, operand latches, index counter, row/column mux and shadow/result registers.

Test Plan:
- Nominal: A={1,2,3,4,5,6,7,8,9}, B={7,3,5,12,11,17,20,3,0} (element 0 first), start pulse -> 9 cycles later done=1 for 1 cycle, Result={91,34,39,208,85,105,325,136,171}; busy high for exactly 9 cycles.
- Identity and zero:
  - A=identity {1,0,0,0,1,0,0,0,1}, B as in nominal -> Result equals B.
  - A=0 -> Result=0.
- Overflow truncation: all elements of A and B = 16'hFFFF -> every Result element = 16'h0003.
- Handshake:
  - start held high for 20 cycles -> exactly 2 operations, each with one done pulse, spaced 10 cycles apart.
  - A modified mid-operation -> Result unaffected.
  - Result holds its old value until the commit edge.
- Reset mid-run: after a completed nominal operation, start a new one and assert rst at cycle 4 -> Result=0, busy=0, done never pulses. A subsequent start with nominal operands yields the nominal Result.
- Power-up: rst for 2 cycles with no start -> Result=0, busy=0, done=0 indefinitely.

Source files
------------

// File: rtl/matrix_calc_pkg.sv
// Shared constants, state encoding and element addressing for the 3x3 matrix multiplier.
// Element k = N*row + col of a packed matrix bus sits at bits [BUS_W-1-DATA_W*k -: DATA_W].
package matrix_calc_pkg;

    localparam int DATA_W   = 16;
    localparam int N        = 3;
    localparam int BUS_W    = N * N * DATA_W;
    localparam int IDX_W    = 4;
    localparam int LAST_IDX = N * N - 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    // LSB position of element (row, col); element (0,0) lives at the MSBs.
    function automatic int elem_lsb(input int row, input int col);
        return BUS_W - DATA_W * (N * row + col + 1);
    endfunction

endpackage

// File: rtl/matrix_dot_product.sv
// Combinational N-term unsigned dot product, truncated to DATA_W bits (modulo 2^DATA_W).
// The low DATA_W bits of a sum of products depend only on the low bits of each term.
module matrix_dot_product
    import matrix_calc_pkg::*;
(
    input  logic [N-1:0][DATA_W-1:0] a_i,
    input  logic [N-1:0][DATA_W-1:0] b_i,
    output logic [DATA_W-1:0]        sum_o
);

    always_comb begin
        // NOTE: combinational logic uses blocking '=' so the accumulation reads in program order;
        // clocked state always uses non-blocking '<='.
        sum_o = '0;
        for (int m = 0; m < N; m++) begin
            sum_o = sum_o + a_i[m] * b_i[m];
        end
    end

endmodule

// File: rtl/matrix3x3_calculator.sv
// Sequential 3x3 matrix multiplier: one result element per clock through a shared dot-product
// unit, then the whole matrix is committed to Result with a one-cycle done pulse.
module matrix3x3_calculator
    import matrix_calc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BUS_W-1:0] A,
    input  logic [BUS_W-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [BUS_W-1:0] Result
);

    state_e                   state_q;
    logic [IDX_W-1:0]         idx_q;
    logic                     busy_q;
    logic                     done_q;
    logic [BUS_W-1:0]         a_q;
    logic [BUS_W-1:0]         b_q;
    logic [BUS_W-1:0]         shadow_q;
    logic [BUS_W-1:0]         shadow_d;
    logic [BUS_W-1:0]         result_q;

    logic [1:0]               row_sel;
    logic [1:0]               col_sel;
    logic [N-1:0][DATA_W-1:0] a_row;
    logic [N-1:0][DATA_W-1:0] b_col;
    logic [DATA_W-1:0]        dot;
    logic                     last_elem;

    // Row of A and column of B feeding the element currently addressed by idx_q.
    always_comb begin
        row_sel = 2'(idx_q / IDX_W'(N));
        col_sel = 2'(idx_q % IDX_W'(N));
        for (int m = 0; m < N; m++) begin
            a_row[m] = a_q[elem_lsb(int'(row_sel), m) +: DATA_W];
            b_col[m] = b_q[elem_lsb(m, int'(col_sel)) +: DATA_W];
        end
        shadow_d = shadow_q;
        shadow_d[elem_lsb(int'(row_sel), int'(col_sel)) +: DATA_W] = dot;
    end

    assign last_elem = (idx_q == IDX_W'(LAST_IDX));

    matrix_dot_product u_dot (
        .a_i   (a_row),
        .b_i   (b_col),
        .sum_o (dot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (last_elem) begin
                        // Commit includes the element being written on this same edge.
                        result_q <= shadow_d;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        idx_q    <= '0;
                        state_q  <= IDLE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // NOTE: operand and shadow registers carry no reset; they are always fully rewritten
    // before being observed, so resetting them would only add load on the reset net.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            a_q <= A;
            b_q <= B;
        end
        if (state_q == RUN) begin
            shadow_q <= shadow_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign Result = result_q;

endmodule

// File: tb/tb_matrix3x3_calculator.sv
// Scoreboard bench for matrix3x3_calculator: stimulus pushes expected matrices, a negedge
// monitor pops and compares on every done pulse; handshake timing is checked alongside.
module tb_matrix3x3_calculator;

    localparam logic [143:0] NOM_A = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
    localparam logic [143:0] NOM_B = {16'd7, 16'd3, 16'd5, 16'd12, 16'd11, 16'd17, 16'd20, 16'd3, 16'd0};
    localparam logic [143:0] NOM_R = {16'd91, 16'd34, 16'd39, 16'd208, 16'd85, 16'd105, 16'd325, 16'd136, 16'd171};
    localparam logic [143:0] ID_M  = {16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1};
    localparam logic [143:0] ONES  = {9{16'hFFFF}};
    localparam logic [143:0] OVF_R = {9{16'h0003}};

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [143:0] A;
    logic [143:0] B;
    logic         busy;
    logic         done;
    logic [143:0] Result;

    int           checks = 0;
    int           errors = 0;
    logic [143:0] exp_q[$];
    logic [143:0] mon_exp;

    matrix3x3_calculator dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .Result (Result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [143:0] got, input logic [143:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] el(input logic [143:0] bus, input int r, input int c);
        return bus[143 - 16 * (3 * r + c) -: 16];
    endfunction

    // Textbook C[i][j] = sum_m A[i][m]*B[m][j] in 64-bit arithmetic, keeping the low 16 bits.
    function automatic logic [143:0] model(input logic [143:0] a, input logic [143:0] b);
        logic [143:0] res;
        res = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                longint unsigned acc;
                acc = 0;
                for (int m = 0; m < 3; m++) begin
                    acc += longint'(el(a, i, m)) * longint'(el(b, m, j));
                end
                res[143 - 16 * (3 * i + j) -: 16] = acc[15:0];
            end
        end
        return res;
    endfunction

    function automatic logic [143:0] rand_bus();
        logic [143:0] v;
        for (int k = 0; k < 9; k++) begin
            v[16 * k +: 16] = 16'($urandom);
        end
        return v;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            check("done_has_expectation", 144'(exp_q.size() != 0), 144'(1));
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check("result", Result, mon_exp);
            end
        end
    end

    task automatic run_op(input logic [143:0] a, input logic [143:0] b, input logic [143:0] exp);
        logic [143:0] prev;
        int           busy_cnt;
        int           lat;
        int           unstable;
        bit           seen;
        @(posedge clk);
        #1;
        A     = a;
        B     = b;
        start = 1'b1;
        exp_q.push_back(exp);
        prev  = Result;
        @(posedge clk);
        #1;
        start    = 1'b0;
        A        = rand_bus();
        B        = rand_bus();
        busy_cnt = 0;
        lat      = 0;
        unstable = 0;
        seen     = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                lat  = c;
            end else begin
                if (busy === 1'b1) busy_cnt++;
                if (Result !== prev) unstable++;
            end
        end
        check("done_latency", 144'(lat), 144'(10));
        check("busy_cycles", 144'(busy_cnt), 144'(9));
        check("result_held_during_run", 144'(unstable), 144'(0));
        @(negedge clk);
        check("done_one_cycle", 144'(done), 144'(0));
        check("busy_low_after", 144'(busy), 144'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        int t1;
        int t2;
        int bad;

        // Power-up: reset with no start, then stay quiet.
        rst   = 1'b1;
        start = 1'b0;
        A     = rand_bus();
        B     = rand_bus();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_result", Result, '0);
        check("reset_busy", 144'(busy), 144'(0));
        check("reset_done", 144'(done), 144'(0));
        rst = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || Result !== '0) bad++;
        end
        check("idle_quiet_after_reset", 144'(bad), 144'(0));

        // Directed cases.
        run_op(NOM_A, NOM_B, NOM_R);
        run_op(ID_M, NOM_B, NOM_B);
        run_op('0, rand_bus(), '0);
        run_op(ONES, ONES, OVF_R);

        // Random cases against the reference model.
        for (int r = 0; r < 8; r++) begin
            logic [143:0] ra;
            logic [143:0] rb;
            ra = rand_bus();
            rb = rand_bus();
            run_op(ra, rb, model(ra, rb));
        end

        // start held high for 20 cycles: two operations, done pulses 10 cycles apart.
        @(posedge clk);
        #1;
        A     = NOM_A;
        B     = NOM_B;
        start = 1'b1;
        exp_q.push_back(NOM_R);
        exp_q.push_back(NOM_R);
        n_done = 0;
        t1     = -1;
        t2     = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (t1 < 0) t1 = i;
                else t2 = i;
            end
            if (i == 20) start = 1'b0;
        end
        check("held_start_ops", 144'(n_done), 144'(2));
        check("held_start_first_done", 144'(t1), 144'(10));
        check("held_start_spacing", 144'(t2 - t1), 144'(10));

        // Reset mid-run aborts the operation and clears Result.
        run_op(NOM_A, NOM_B, NOM_R);
        @(posedge clk);
        #1;
        A     = ONES;
        B     = ONES;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_result", Result, '0);
        check("abort_busy", 144'(busy), 144'(0));
        check("abort_done", 144'(done), 144'(0));
        rst = 1'b0;
        bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("abort_no_done", 144'(bad), 144'(0));
        run_op(NOM_A, NOM_B, NOM_R);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 144'(exp_q.size()), 144'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
